// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling FSM and a
// small byte FIFO that presents received bytes over a valid/ready interface.
module uart_byte_receiver #(
  parameter int CLOCKS_PER_BIT = 1250,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                               clock_144mhz,
  input  logic                               reset_n,
  input  logic                               uart_rx,
  output logic [7:0]                         rx_data,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_level,
  output logic                               framing_error,
  output logic                               overrun
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  logic             sync1_q;
  logic             rx_s_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             framing_error_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             overrun_q;

  logic             bit_tick;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;

  // Input synchronizer; flops reset to the idle-high line level.
  always_ff @(posedge clock_144mhz) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      rx_s_q  <= sync1_q;
    end
  end

  assign bit_tick = (cnt_q == '0);
  assign push     = (state_q == S_STOP) && bit_tick && rx_s_q;

  // Receive FSM: the counter only runs while a frame is in progress.
  always_ff @(posedge clock_144mhz) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      framing_error_q <= 1'b0;
    end else begin
      framing_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= HALF_M1;
          end
        end
        S_START: begin
          if (bit_tick) begin
            if (!rx_s_q) begin
              state_q   <= S_DATA;
              cnt_q     <= BIT_M1;
              bit_idx_q <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            cnt_q <= BIT_M1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            if (rx_s_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q         <= S_WAIT_IDLE;
              framing_error_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_144mhz) begin
    if ((state_q == S_DATA) && bit_tick) begin
      shift_q <= {rx_s_q, shift_q[7:1]};
    end
  end

  // Byte FIFO: a pop frees a slot in the same cycle, so push-while-full-with-pop is accepted.
  assign pop   = (level_q != '0) && rx_ready;
  assign full  = (level_q == FULL_LVL);
  assign wr_en = push && (!full || pop);

  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock_144mhz) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      overrun_q <= push && full && !pop;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clock_144mhz) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rx_valid      = (level_q != '0);
  assign rx_data       = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign rx_level      = level_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver: stimulus queues expected bytes, a negedge
// monitor pops and compares every accepted byte and counts error pulses.
module tb_uart_byte_receiver;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] rx_level;
  logic       framing_error;
  logic       overrun;

  always #5 clk = ~clk;

  uart_byte_receiver #(
    .CLOCKS_PER_BIT(CPB),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clock_144mhz (clk),
    .reset_n      (reset_n),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_level     (rx_level),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  int         checks  = 0;
  int         errors  = 0;
  int         fe_cnt  = 0;
  int         ov_cnt  = 0;
  int         rx_cnt  = 0;
  int         max_lvl = 0;
  bit         track   = 1'b0;
  bit         done6   = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drives the first nbits of a frame {stop, data, start}, LSB first, CPB cycles per bit.
  task automatic send_bits(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      #1 uart_rx = fr[i];
      repeat (CPB) @(posedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b1, 10);
  endtask

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (reset_n === 1'b1) begin
      if (framing_error === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (track && int'(rx_level) > max_lvl) max_lvl = int'(rx_level);
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
        rx_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got 0x%02h, expected no byte", rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL rx_byte: got 0x%02h, expected 0x%02h", rx_data, e);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_level", int'(rx_level), 0);
    check("reset_data", int'(rx_data), 0);
    check("reset_fe", int'(framing_error), 0);
    check("reset_ov", int'(overrun), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // Test 1: 0xA5 with latency measurement.
    #1 rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    fork
      send_byte(8'hA5);
      begin
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (n < 300) begin
          @(negedge clk);
          n++;
          if (rx_valid === 1'b1) break;
        end
        check("t1_valid_latency", n, 156);
      end
    join
    repeat (5) @(posedge clk);
    check("t1_rx_count", rx_cnt, 1);
    check("t1_fe_count", fe_cnt, 0);
    check("t1_ov_count", ov_cnt, 0);

    // Test 2: short low glitch.
    @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("t2_level", int'(rx_level), 0);
    check("t2_rx_count", rx_cnt, 1);
    check("t2_fe_count", fe_cnt, 0);
    check("t2_ov_count", ov_cnt, 0);

    // Test 3: bad stop bit followed by a held break, then a good byte.
    send_bits(8'h3C, 1'b0, 10);
    repeat (40) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("t3_fe_count", fe_cnt, 1);
    check("t3_level", int'(rx_level), 0);
    check("t3_ov_count", ov_cnt, 0);
    exp_q.push_back(8'h11);
    send_byte(8'h11);
    repeat (10) @(posedge clk);
    check("t3_rx_count", rx_cnt, 2);
    check("t3_fe_after", fe_cnt, 1);

    // Test 4: fill past capacity, then drain.
    #1 rx_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(8'(v));
      send_byte(8'(v));
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t4_level_full", int'(rx_level), 4);
    check("t4_ov_count", ov_cnt, 1);
    check("t4_head", int'(rx_data), 1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_level_drained", int'(rx_level), 0);
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_rx_count", rx_cnt, 6);

    // Test 5: reset in the middle of a frame with a byte already buffered.
    @(posedge clk);
    #1 rx_ready = 1'b0;
    send_byte(8'h99);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_level_before", int'(rx_level), 1);
    fork
      send_bits(8'h77, 1'b1, 6);
      begin
        @(posedge clk);
        repeat (CPB * 5 + 8) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("t5_reset_valid", int'(rx_valid), 0);
        check("t5_reset_level", int'(rx_level), 0);
        check("t5_reset_data", int'(rx_data), 0);
        check("t5_reset_fe", int'(framing_error), 0);
        check("t5_reset_ov", int'(overrun), 0);
      end
    join
    #1 uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    check("t5_fe_count", fe_cnt, 1);
    check("t5_ov_count", ov_cnt, 1);
    #1 rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_byte(8'hC3);
    repeat (10) @(posedge clk);
    check("t5_rx_count", rx_cnt, 7);

    // Test 6: back-to-back frames with rx_ready toggling every cycle.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    max_lvl = 0;
    track   = 1'b1;
    fork
      begin
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h55);
        repeat (20) @(posedge clk);
        done6 = 1'b1;
      end
      begin
        while (!done6) begin
          @(posedge clk);
          #1 rx_ready = ~rx_ready;
        end
      end
    join
    track = 1'b0;
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_rx_count", rx_cnt, 10);
    check("t6_ov_count", ov_cnt, 1);
    check("t6_fe_count", fe_cnt, 1);
    check("t6_max_level_le2", int'(max_lvl <= 2), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
